// File: rtl/mult_pkg.sv
// Shared constants and the in-flight tag type for the multiplier-sharing arbiter.
// Tag ids are sized for the largest supported requester count (8).
package mult_pkg;

   localparam int MUL_W    = 4;
   localparam int PROD_W   = 8;
   localparam int MUL_LAT  = 3;
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin pick among requesters, starting from a registered pointer that
// moves one past the most recent winner.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_gnt_idx
);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_cand;
   logic [ID_W-1:0] w_idx;
   logic            w_found;
   logic            w_gnt_vld;

   // Walk the requesters from the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      w_sum   = '0;
      w_cand  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         w_cand = w_sum[ID_W-1:0];
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   // Grants are suppressed while reset is asserted so the operand mux stays quiet.
   assign w_gnt_vld = w_found & rst_n;
   assign o_gnt_idx = w_idx;

   always_comb begin
      o_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_grant[i] = w_gnt_vld && (w_idx == ID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_gnt_vld) begin
         r_ptr <= (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined 4x4 multiplier between NUM_REQ requesters; a tag delay line
// matched to the multiplier latency routes each product back to its issuer.
module mult_share_arbiter
   import mult_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LAT     = MUL_LAT,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [MUL_W*NUM_REQ-1:0] req_a,
   input  logic [MUL_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [PROD_W-1:0]        rsp_p,
   output logic [MUL_W-1:0]         mul_a,
   output logic [MUL_W-1:0]         mul_b,
   input  logic [PROD_W-1:0]        mul_p,
   output logic                     busy
);

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_gnt_idx;
   logic               w_hs;
   tag_t               r_tag [LAT];
   tag_t               w_out_tag;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req_valid),
      .o_grant   (w_grant),
      .o_gnt_idx (w_gnt_idx)
   );

   assign req_ready = w_grant;
   assign w_hs      = |(req_valid & w_grant);

   // One-hot grant selects the winner's operands; idle cycles present zeros.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            mul_a = req_a[i*MUL_W +: MUL_W];
            mul_b = req_b[i*MUL_W +: MUL_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < LAT; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         r_tag[0].vld <= w_hs;
         r_tag[0].id  <= TAG_ID_W'(w_gnt_idx);
         for (int s = 1; s < LAT; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   assign w_out_tag = r_tag[LAT-1];

   // The last tag stage lines up with the multiplier output in the same cycle.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = w_out_tag.vld && (w_out_tag.id == TAG_ID_W'(i));
      end
      rsp_p = w_out_tag.vld ? mul_p : '0;
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < LAT; s++) begin
         busy = busy | r_tag[s].vld;
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench: the stimulus side predicts grants and products from a
// round-robin model; a separate monitor checks every returned product.
module tb_mult_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int LAT     = 3;
   localparam int ID_W    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_p;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;
   logic        busy;

   logic [7:0]  p0, p1, p2;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int mptr = 0;

   typedef struct {
      int id;
      int prod;
      int due;
   } exp_t;

   exp_t sb[$];

   mult_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .LAT     (LAT),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_p     (rsp_p),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the shared three-stage multiplier, reset together with the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0 <= '0;
         p1 <= '0;
         p2 <= '0;
      end else begin
         p0 <= 8'(mul_a) * 8'(mul_b);
         p1 <= p0;
         p2 <= p1;
      end
   end
   assign mul_p = p2;

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic int pickGrant(input logic [3:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic logic [15:0] pack4(input int x0, input int x1, input int x2, input int x3);
      return {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
   endfunction

   // Compares the grant and operand mux against the model and queues the product.
   task automatic checkOutput(output int g);
      exp_t e;
      int   ea;
      int   eb;
      @(negedge clk);
      g  = pickGrant(req_valid, mptr);
      ea = (g >= 0) ? int'((req_a >> (4*g)) & 16'hF) : 0;
      eb = (g >= 0) ? int'((req_b >> (4*g)) & 16'hF) : 0;
      checkValue("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      checkValue("mul_a", mul_a, ea);
      checkValue("mul_b", mul_b, eb);
      if (g >= 0) begin
         e.id   = g;
         e.prod = ea * eb;
         e.due  = cyc + LAT;
         sb.push_back(e);
         mptr = (g + 1) % NUM_REQ;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [15:0] a,
                                input logic [15:0] b, output int g);
      @(posedge clk);
      #1;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      checkOutput(g);
   endtask

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) applyStimulus(4'b0000, 16'h0, 16'h0, g);
   endtask

   task automatic checkResetOutputs();
      checkValue("rst_req_ready", req_ready, 0);
      checkValue("rst_rsp_valid", rsp_valid, 0);
      checkValue("rst_rsp_p", rsp_p, 0);
      checkValue("rst_busy", busy, 0);
      checkValue("rst_mul_a", mul_a, 0);
      checkValue("rst_mul_b", mul_b, 0);
   endtask

   // Asynchronous assert mid-cycle with requesters still asking; in-flight work is dropped.
   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_a     = 16'hFFFF;
      req_b     = 16'hFFFF;
      sb.delete();
      mptr = 0;
      #1;
      checkResetOutputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   // Monitor: every cycle either a queued product is due or the response port is quiet.
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            checkValue("rsp_missing_id", -1, sb[0].id);
            void'(sb.pop_front());
         end
         checkValue("busy", busy, int'(sb.size() > 0 && sb[0].due <= cyc + LAT - 1));
         if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checkValue("rsp_valid", rsp_valid, 1 << e.id);
            checkValue("rsp_p", rsp_p, e.prod);
         end else begin
            checkValue("rsp_valid_idle", rsp_valid, 0);
            checkValue("rsp_p_idle", rsp_p, 0);
         end
      end
   end

   initial begin
      int          g;
      logic [3:0]  pend;
      logic [15:0] a;
      logic [15:0] b;

      #2;
      checkResetOutputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] single op");
      applyStimulus(4'b0001, pack4(3, 0, 0, 0), pack4(2, 0, 0, 0), g);
      idle(5);

      $display("[TB] back-to-back same requester");
      applyStimulus(4'b0010, pack4(0, 7, 0, 0), pack4(0, 4, 0, 0), g);
      applyStimulus(4'b0010, pack4(0, 9, 0, 0), pack4(0, 3, 0, 0), g);
      applyStimulus(4'b0010, pack4(0, 15, 0, 0), pack4(0, 15, 0, 0), g);
      applyStimulus(4'b1000, pack4(0, 0, 0, 4), pack4(0, 0, 0, 5), g);
      idle(4);

      $display("[TB] full contention and rotation");
      a    = pack4(6, 2, 5, 1);
      b    = pack4(8, 2, 3, 15);
      pend = 4'b1111;
      for (int i = 0; i < 8 && pend != 0; i++) begin
         applyStimulus(pend, a, b, g);
         if (g >= 0) pend[g] = 1'b0;
      end
      pend = 4'b0101;
      a    = pack4(10, 0, 11, 0);
      b    = pack4(12, 0, 13, 0);
      for (int i = 0; i < 4 && pend != 0; i++) begin
         applyStimulus(pend, a, b, g);
         if (g >= 0) pend[g] = 1'b0;
      end
      idle(4);

      $display("[TB] idle gaps");
      for (int gap = 2; gap <= 4; gap += 2) begin
         for (int r = 0; r < 3; r++) begin
            applyStimulus(4'(1 << $urandom_range(0, 3)), 16'($urandom), 16'($urandom), g);
            idle(gap);
         end
      end
      idle(3);

      $display("[TB] reset mid-flight");
      for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 16'($urandom), 16'($urandom), g);
      doReset();
      idle(5);
      applyStimulus(4'b1111, pack4(5, 6, 7, 8), pack4(9, 10, 11, 12), g);
      idle(4);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), g);
      end
      idle(6);

      checkValue("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
